uart_receiver: RTL

//   Serial-to-parallel UART receiver. Consumes the 16x-oversampling tick from the baud rate generator.

---
 rtl/uart_receiver.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/uart_receiver.sv
// 16x-oversampling UART receiver: start-bit qualification, mid-bit sampling,
// parity/stop checking and a valid/ack host handshake with sticky overrun.
module uart_receiver (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ov_baud_rt_i,
  input  logic       rx_i,
  input  logic [1:0] data_width_i,
  input  logic       parity_en_i,
  input  logic       parity_odd_i,
  input  logic       stop_bits_i,
  input  logic       rx_ack_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       parity_err_o,
  output logic       frame_err_o,
  output logic       overrun_err_o,
  output logic       rx_busy_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t     r_state;
  logic       r_rxMeta;
  logic       r_rxSync;
  logic [3:0] r_tickCnt;
  logic [2:0] r_bitCnt;
  logic [7:0] r_shift;
  logic [1:0] r_width;
  logic       r_parEn;
  logic       r_parOdd;
  logic       r_twoStop;
  logic       r_stopCnt;
  logic       r_parErr;
  logic       r_frmErr;
  logic       r_done;
  logic [2:0] w_lastBit;

  // Index of the final data bit: 4 for 5-bit words up to 7 for 8-bit words.
  assign w_lastBit = 3'd4 + {1'b0, r_width};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rxMeta <= 1'b1;
      r_rxSync <= 1'b1;
    end else begin
      r_rxMeta <= rx_i;
      r_rxSync <= r_rxMeta;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      rx_busy_o <= 1'b0;
      r_tickCnt <= 4'd0;
      r_bitCnt  <= 3'd0;
      r_shift   <= 8'h00;
      r_width   <= 2'b00;
      r_parEn   <= 1'b0;
      r_parOdd  <= 1'b0;
      r_twoStop <= 1'b0;
      r_stopCnt <= 1'b0;
      r_parErr  <= 1'b0;
      r_frmErr  <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (ov_baud_rt_i) begin
        case (r_state)
          S_IDLE: begin
            if (!r_rxSync) begin
              r_state   <= S_START;
              rx_busy_o <= 1'b1;
              r_tickCnt <= 4'd0;
              r_width   <= data_width_i;
              r_parEn   <= parity_en_i;
              r_parOdd  <= parity_odd_i;
              r_twoStop <= stop_bits_i;
            end
          end
          S_START: begin
            if (r_tickCnt != 4'd7) begin
              r_tickCnt <= r_tickCnt + 4'd1;
            end else if (r_rxSync) begin
              r_state   <= S_IDLE;
              rx_busy_o <= 1'b0;
            end else begin
              r_state   <= S_DATA;
              r_tickCnt <= 4'd0;
              r_bitCnt  <= 3'd0;
              r_shift   <= 8'h00;
              r_stopCnt <= 1'b0;
              r_parErr  <= 1'b0;
              r_frmErr  <= 1'b0;
            end
          end
          S_DATA: begin
            if (r_tickCnt != 4'd15) begin
              r_tickCnt <= r_tickCnt + 4'd1;
            end else begin
              r_tickCnt          <= 4'd0;
              r_shift[r_bitCnt]  <= r_rxSync;
              r_bitCnt           <= r_bitCnt + 3'd1;
              if (r_bitCnt == w_lastBit) begin
                r_state <= r_parEn ? S_PARITY : S_STOP;
              end
            end
          end
          S_PARITY: begin
            if (r_tickCnt != 4'd15) begin
              r_tickCnt <= r_tickCnt + 4'd1;
            end else begin
              r_tickCnt <= 4'd0;
              r_parErr  <= ((^r_shift) ^ r_rxSync) != r_parOdd;
              r_state   <= S_STOP;
            end
          end
          S_STOP: begin
            if (r_tickCnt != 4'd15) begin
              r_tickCnt <= r_tickCnt + 4'd1;
            end else begin
              r_tickCnt <= 4'd0;
              if (!r_rxSync) begin
                r_frmErr <= 1'b1;
              end
              // Completion drops straight to IDLE so the next start edge is seen early.
              if (r_twoStop && !r_stopCnt) begin
                r_stopCnt <= 1'b1;
              end else begin
                r_state   <= S_IDLE;
                rx_busy_o <= 1'b0;
                r_done    <= 1'b1;
              end
            end
          end
          default: begin
            r_state   <= S_IDLE;
            rx_busy_o <= 1'b0;
          end
        endcase
      end
    end
  end

  // An ack coinciding with a completed frame frees the slot for that frame.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_data_o     <= 8'h00;
      rx_valid_o    <= 1'b0;
      parity_err_o  <= 1'b0;
      frame_err_o   <= 1'b0;
      overrun_err_o <= 1'b0;
    end else if (r_done) begin
      if (!rx_valid_o || rx_ack_i) begin
        rx_data_o     <= r_shift;
        parity_err_o  <= r_parErr;
        frame_err_o   <= r_frmErr;
        rx_valid_o    <= 1'b1;
        overrun_err_o <= 1'b0;
      end else begin
        overrun_err_o <= 1'b1;
      end
    end else if (rx_ack_i && rx_valid_o) begin
      rx_valid_o    <= 1'b0;
      parity_err_o  <= 1'b0;
      frame_err_o   <= 1'b0;
      overrun_err_o <= 1'b0;
    end
  end

endmodule
